// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA channel scheduler.
// Holds the channel count, index width, FSM state type and the grant counter helper.
package dma_pkg;

    localparam int DMA_NUM_CH = 128;
    localparam int DMA_IDX_W  = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OFFER = 2'd1,
        BUSY  = 2'd2
    } sched_state_t;

    // Debug counter sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : (v + 16'd1);
    endfunction

endpackage

// File: rtl/rr_prio_enc.sv
// Combinational round-robin priority encoder.
// Finds the first set request searching upward from i_ptr, wrapping at NUM_CH-1.
module rr_prio_enc
    import dma_pkg::*;
#(
    parameter int NUM_CH = DMA_NUM_CH,
    parameter int IDX_W  = DMA_IDX_W
) (
    input  logic [NUM_CH-1:0] i_req,
    input  logic [IDX_W-1:0]  i_ptr,
    output logic              o_found,
    output logic [IDX_W-1:0]  o_idx
);

    logic [2*NUM_CH-1:0] w_dbl;
    logic [2*NUM_CH-1:0] w_shift;
    logic [NUM_CH-1:0]   w_rot;
    logic [IDX_W-1:0]    w_off;
    logic [IDX_W:0]      w_sum;

    assign w_dbl   = {i_req, i_req};
    assign w_shift = w_dbl >> i_ptr;
    assign w_rot   = w_shift[NUM_CH-1:0];
    assign o_found = |i_req;

    // Lowest set bit of the rotated vector is the offset from the pointer.
    always_comb begin
        w_off = {IDX_W{1'b0}};
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            w_off = w_rot[i] ? IDX_W'(i) : w_off;
        end
    end

    // Undo the rotation, folding back into range for non power-of-two counts.
    always_comb begin
        w_sum = {1'b0, w_off} + {1'b0, i_ptr};
        if (w_sum >= (IDX_W+1)'(NUM_CH)) begin
            o_idx = IDX_W'(w_sum - (IDX_W+1)'(NUM_CH));
        end else begin
            o_idx = w_sum[IDX_W-1:0];
        end
    end

endmodule

// File: rtl/dma_chan_scheduler.sv
// Round-robin DMA channel scheduler: offers one qualified channel, holds it until
// the engine accepts and completes it, then advances the pointer past it.
module dma_chan_scheduler
    import dma_pkg::*;
#(
    parameter int NUM_CH = DMA_NUM_CH,
    parameter int IDX_W  = DMA_IDX_W
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic [NUM_CH-1:0] dma_req,
    input  logic [NUM_CH-1:0] chan_en,
    input  logic              sched_en,
    input  logic              sel_ready,
    input  logic              xfer_done,
    output logic              sel_valid,
    output logic [IDX_W-1:0]  sel_idx,
    output logic              busy,
    output logic [15:0]       grant_cnt
);

    sched_state_t      r_state;
    sched_state_t      w_next_state;
    logic [IDX_W-1:0]  r_sel_idx;
    logic [IDX_W-1:0]  r_rr_ptr;
    logic [15:0]       r_grant_cnt;
    logic [NUM_CH-1:0] w_q;
    logic              w_found;
    logic [IDX_W-1:0]  w_pick;
    logic              w_offer_live;

    assign w_q          = dma_req & chan_en;
    assign w_offer_live = w_q[r_sel_idx];

    rr_prio_enc #(.NUM_CH(NUM_CH), .IDX_W(IDX_W)) u_enc (
        .i_req   (w_q),
        .i_ptr   (r_rr_ptr),
        .o_found (w_found),
        .o_idx   (w_pick)
    );

    // State register.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; an accept in OFFER takes priority over a dropped request.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (sched_en && w_found) begin
                    w_next_state = OFFER;
                end else begin
                    w_next_state = IDLE;
                end
            end
            OFFER: begin
                if (sel_ready) begin
                    w_next_state = BUSY;
                end else if (!w_offer_live) begin
                    w_next_state = IDLE;
                end else begin
                    w_next_state = OFFER;
                end
            end
            BUSY: begin
                if (xfer_done) begin
                    w_next_state = IDLE;
                end else begin
                    w_next_state = BUSY;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Index, pointer and counter; sel_idx only moves on IDLE->OFFER so the decoder never glitches.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_sel_idx   <= {IDX_W{1'b0}};
            r_rr_ptr    <= {IDX_W{1'b0}};
            r_grant_cnt <= 16'd0;
        end else begin
            if ((r_state == IDLE) && (w_next_state == OFFER)) begin
                r_sel_idx <= w_pick;
            end
            if ((r_state == OFFER) && sel_ready) begin
                r_grant_cnt <= sat_inc16(r_grant_cnt);
            end
            if ((r_state == BUSY) && xfer_done) begin
                r_rr_ptr <= (r_sel_idx == IDX_W'(NUM_CH - 1)) ? {IDX_W{1'b0}}
                                                              : (r_sel_idx + IDX_W'(1));
            end
        end
    end

    // Output decode from registered state.
    always_comb begin
        sel_idx   = r_sel_idx;
        grant_cnt = r_grant_cnt;
        case (r_state)
            OFFER: begin
                sel_valid = 1'b1;
                busy      = 1'b0;
            end
            BUSY: begin
                sel_valid = 1'b1;
                busy      = 1'b1;
            end
            default: begin
                sel_valid = 1'b0;
                busy      = 1'b0;
            end
        endcase
    end

endmodule
